// File: rtl/shot_referee.sv
// shot_referee: game-round controller behind the trajectory calculator.
// It keeps the score and the shot budget, and it drives pseudo-random
// targets back to the calculator. It lets only one shot be in flight at a time.
// Optional feature: define MISS_HINT_EN to register |positionx-target_x| of
// the last miss on miss_dist. When it is not defined, miss_dist is tied to 0.
module shot_referee #(
  parameter int         SHOTS_PER_GAME = 8,
  parameter int         SCORE_W        = 4,
  parameter logic [9:0] LFSR_SEED      = 10'h2A5
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ena,
  input  logic                                  start,
  input  logic                                  result_valid,
  input  logic                                  hit,
  input  logic [4:0]                            positionx,
  output logic                                  shot_enable,
  output logic [4:0]                            target_x,
  output logic [4:0]                            target_y,
  output logic [$clog2(SHOTS_PER_GAME+1)-1:0]   shots_left,
  output logic [SCORE_W-1:0]                    score,
  output logic                                  game_over,
  output logic [4:0]                            miss_dist
);

  localparam int         SL_W      = $clog2(SHOTS_PER_GAME+1);
  localparam logic [9:0] SEED      = (LFSR_SEED == 10'd0) ? 10'h001 : LFSR_SEED;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ARMED, SETTLE, OVER} state_t;

  state_t     state, state_nx;
  logic [9:0] lfsr;
  logic       new_game, shot_done, load;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_nx;
  end

  // Next state and per-cycle events. A start in IDLE/OVER wins over a result
  // in the same cycle, because results count only in ARMED.
  always_comb begin
    state_nx  = state;
    new_game  = 1'b0;
    shot_done = 1'b0;
    case (state)
      IDLE, OVER: if (start) begin
        state_nx = ARMED;
        new_game = 1'b1;
      end
      ARMED: if (result_valid) begin
        shot_done = 1'b1;
        state_nx  = (shots_left == SL_W'(1)) ? OVER : SETTLE;
      end
      SETTLE:  state_nx = ARMED;
      default: state_nx = IDLE;
    endcase
  end

  assign load        = new_game | (shot_done & hit);
  assign shot_enable = (state == ARMED);
  assign game_over   = (state == OVER);

  // Shot budget and saturating score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shots_left <= '0;
      score      <= '0;
    end else if (ena) begin
      if (new_game) begin
        shots_left <= SL_W'(SHOTS_PER_GAME);
        score      <= '0;
      end else if (shot_done) begin
        shots_left <= shots_left - 1'b1;
        if (hit && score != SCORE_MAX) score <= score + 1'b1;
      end
    end
  end

  // Target generator. The LFSR steps only when a target is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr     <= SEED;
      target_x <= '0;
      target_y <= '0;
    end else if (ena && load) begin
      target_x <= lfsr[4:0];
      target_y <= (lfsr[9:5] == 5'd0) ? 5'd1 : lfsr[9:5];
      lfsr     <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end
  end

`ifdef MISS_HINT_EN
  // Distance of the last miss from the target. It clears on a hit or on a new game.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miss_dist <= '0;
    else if (ena) begin
      if (new_game || (shot_done && hit))
        miss_dist <= '0;
      else if (shot_done)
        miss_dist <= (positionx >= target_x) ? positionx - target_x
                                             : target_x - positionx;
    end
  end
`else
  logic unused_pos;
  assign unused_pos = ^positionx;
  assign miss_dist  = 5'd0;
`endif

endmodule

// File: tb/tb_shot_referee.sv
// Bench for shot_referee. It runs three instances on shared stimulus:
// (8 shots, 4-bit score), (8 shots, 2-bit score) and (1 shot, 4-bit score).
// The checks are a vector table, hand-written corner sequences and a random
// run compared against a game-level reference model.
module tb_shot_referee;
  logic       clk = 1'b0, rst_n = 1'b1, ena = 1'b0, start = 1'b0;
  logic       result_valid = 1'b0, hit = 1'b0;
  logic [4:0] positionx = '0;

  always #5 clk = ~clk;

  logic       se0, go0, se1, go1, se2, go2;
  logic [4:0] tx0, ty0, md0, tx1, ty1, md1, tx2, ty2, md2;
  logic [3:0] sl0, sl1, sc0, sc2;
  logic [0:0] sl2;
  logic [1:0] sc1;

  shot_referee #(.SHOTS_PER_GAME(8), .SCORE_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .result_valid(result_valid),
    .hit(hit), .positionx(positionx), .shot_enable(se0), .target_x(tx0), .target_y(ty0),
    .shots_left(sl0), .score(sc0), .game_over(go0), .miss_dist(md0));
  shot_referee #(.SHOTS_PER_GAME(8), .SCORE_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .result_valid(result_valid),
    .hit(hit), .positionx(positionx), .shot_enable(se1), .target_x(tx1), .target_y(ty1),
    .shots_left(sl1), .score(sc1), .game_over(go1), .miss_dist(md1));
  shot_referee #(.SHOTS_PER_GAME(1), .SCORE_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .result_valid(result_valid),
    .hit(hit), .positionx(positionx), .shot_enable(se2), .target_x(tx2), .target_y(ty2),
    .shots_left(sl2), .score(sc2), .game_over(go2), .miss_dist(md2));

`ifdef MISS_HINT_EN
  localparam int HINT = 1;
`else
  localparam int HINT = 0;
`endif

  int tests = 0, fails = 0;

  // Reference model, per instance: mode 0=idle 1=armed 2=settle 3=over.
  int seq[4096];
  int p_s[3] = '{8, 8, 1};
  int p_m[3] = '{15, 3, 15};
  int m_mode[3], m_sl[3], m_hits[3], m_loads[3], m_md[3];

  typedef struct {
    logic ena, start, rv, hit;
    int   pos;
    int   se, go, tx, ty, sl, sc, md;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int tx_of(int n);
    return (n == 0) ? 0 : (seq[n-1] & 31);
  endfunction

  function automatic int ty_of(int n);
    int y;
    if (n == 0) return 0;
    y = (seq[n-1] >> 5) & 31;
    return (y == 0) ? 1 : y;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_mode[k] = 0; m_sl[k] = 0; m_hits[k] = 0; m_loads[k] = 0; m_md[k] = 0;
    end
  endtask

  task automatic model_clock();
    int d;
    if (!ena) return;
    for (int k = 0; k < 3; k++) begin
      if (m_mode[k] == 0 || m_mode[k] == 3) begin
        if (start) begin
          m_mode[k] = 1; m_sl[k] = p_s[k]; m_hits[k] = 0; m_md[k] = 0; m_loads[k]++;
        end
      end else if (m_mode[k] == 2) begin
        m_mode[k] = 1;
      end else if (result_valid) begin
        m_sl[k]--;
        if (hit) begin
          m_hits[k]++; m_loads[k]++; m_md[k] = 0;
        end else begin
          d = int'(positionx) - tx_of(m_loads[k]);
          m_md[k] = (d < 0) ? -d : d;
        end
        m_mode[k] = (m_sl[k] == 0) ? 3 : 2;
      end
    end
  endtask

  task automatic get(input int k, output int se, go, tx, ty, sl, sc, md);
    case (k)
      0: begin se = se0; go = go0; tx = tx0; ty = ty0; sl = sl0; sc = sc0; md = md0; end
      1: begin se = se1; go = go1; tx = tx1; ty = ty1; sl = sl1; sc = sc1; md = md1; end
      default: begin se = se2; go = go2; tx = tx2; ty = ty2; sl = sl2; sc = sc2; md = md2; end
    endcase
  endtask

  task automatic check_model();
    int se, go, tx, ty, sl, sc, md;
    for (int k = 0; k < 3; k++) begin
      get(k, se, go, tx, ty, sl, sc, md);
      chk($sformatf("u%0d.shot_enable", k), se, (m_mode[k] == 1) ? 1 : 0);
      chk($sformatf("u%0d.game_over", k), go, (m_mode[k] == 3) ? 1 : 0);
      chk($sformatf("u%0d.target_x", k), tx, tx_of(m_loads[k]));
      chk($sformatf("u%0d.target_y", k), ty, ty_of(m_loads[k]));
      chk($sformatf("u%0d.shots_left", k), sl, m_sl[k]);
      chk($sformatf("u%0d.score", k), sc, (m_hits[k] > p_m[k]) ? p_m[k] : m_hits[k]);
      chk($sformatf("u%0d.miss_dist", k), md, HINT ? m_md[k] : 0);
    end
  endtask

  // The inputs are set at a falling edge. The model is updated at the rising
  // edge, and the outputs are checked at the next falling edge.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic s, input logic rv, input logic h, input int p);
    ena = 1'b1; start = s; result_valid = rv; hit = h; positionx = 5'(p);
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("rst.shot_enable", se0, 0); chk("rst.game_over", go0, 0);
    chk("rst.target_x", tx0, 0);    chk("rst.target_y", ty0, 0);
    chk("rst.shots_left", sl0, 0);  chk("rst.score", sc0, 0);
    chk("rst.miss_dist", md0, 0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; result_valid = 1'b0; hit = 1'b0;
  endtask

  initial begin
    seq[0] = 'h2A5;
    for (int i = 0; i < 4095; i++)
      seq[i+1] = ((seq[i] << 1) & 'h3FF) | (((seq[i] >> 9) ^ (seq[i] >> 6)) & 1);

    //              ena st rv ht pos  se go tx  ty  sl sc md
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 0, 5, 21, 8, 0, 0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 5, 21, 8, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 11, 10, 7, 1, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 0, 11, 10, 7, 1, 0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 2, 0, 0, 11, 10, 6, 1, HINT ? 9 : 0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1, 0, 11, 10, 6, 1, HINT ? 9 : 0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 0, 11, 10, 6, 1, HINT ? 9 : 0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 0, 11, 10, 6, 1, HINT ? 9 : 0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 0, 11, 10, 6, 1, HINT ? 9 : 0};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 23, 20, 5, 2, 0};

    #3;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      ena = tbl[i].ena; start = tbl[i].start; result_valid = tbl[i].rv;
      hit = tbl[i].hit; positionx = 5'(tbl[i].pos);
      step();
      chk($sformatf("vec%0d.shot_enable", i), se0, tbl[i].se);
      chk($sformatf("vec%0d.game_over", i), go0, tbl[i].go);
      chk($sformatf("vec%0d.target_x", i), tx0, tbl[i].tx);
      chk($sformatf("vec%0d.target_y", i), ty0, tbl[i].ty);
      chk($sformatf("vec%0d.shots_left", i), sl0, tbl[i].sl);
      chk($sformatf("vec%0d.score", i), sc0, tbl[i].sc);
      chk($sformatf("vec%0d.miss_dist", i), md0, tbl[i].md);
    end

    // Reset in the middle of a game (u0 is ARMED here).
    drive(0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // A fresh game, then a miss at x=2 against target x=5.
    drive(1, 0, 0, 0);
    chk("seqB.target_x", tx0, 5);
    drive(0, 1, 0, 2);
    chk("seqB.miss_dist", md0, HINT ? 3 : 0);
    chk("seqB.shots_left", sl0, 7);
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0);
      drive(0, 1, 0, $urandom_range(0, 31));
    end
    chk("seqC.shots_left", sl0, 0);
    chk("seqC.game_over", go0, 1);
    chk("seqC.shot_enable", se0, 0);
    drive(0, 1, 1, 0);
    chk("seqC.over_ignores_result", sc0, 0);
    drive(1, 1, 1, 0);
    chk("seqC.restart_shots", sl0, 8);
    chk("seqC.restart_score", sc0, 0);
    chk("seqC.restart_armed", se0, 1);

    // Five hits: the 2-bit score saturates, and a 1-shot game ends at once.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0);
      if (i == 0) begin
        chk("seqD.one_shot_over", go2, 1);
        chk("seqD.one_shot_left", sl2, 0);
      end
      drive(0, 0, 0, 0);
    end
    chk("seqD.sat_score", sc1, 3);
    chk("seqD.score", sc0, 5);
    chk("seqD.shots_left", sl1, 3);

    // Random run against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        ena          = ($urandom_range(0, 9) != 0);
        start        = ($urandom_range(0, 9) == 0);
        result_valid = ($urandom_range(0, 9) < 4);
        hit          = $urandom_range(0, 1) == 1;
        positionx    = 5'($urandom_range(0, 31));
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
